// File: rtl/ecdh_seq.sv
// ecdh_seq: host-stream sequencer that loads operands, runs one scalar multiplication and streams back the result
module ecdh_seq #(
    parameter int            BW      = 192,
    parameter int            IO_W    = 32,
    parameter logic [BW-1:0] GEN_X   = 192'h188DA80EB03090F67CBF20EB43A18800F4FF0AFD82FF1012,
    parameter logic [BW-1:0] GEN_Y   = 192'h07192B95FFC8DA78631011ED6B24CDD573F977A11E794811,
    parameter int            TIMEOUT = 2**20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic            cmd_op,
    output logic            cmd_ready,
    input  logic            in_valid,
    input  logic [IO_W-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [IO_W-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            done,
    output logic [1:0]      status,
    output logic            mul_start,
    output logic [BW-1:0]   mul_k,
    output logic [BW-1:0]   mul_Px,
    output logic [BW-1:0]   mul_Py,
    input  logic [BW-1:0]   mul_Qx,
    input  logic [BW-1:0]   mul_Qy,
    input  logic            mul_valid
);
    localparam int W  = BW / IO_W;
    localparam int CW = $clog2(3 * W + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, START, WAIT, OUT, FIN} state_t;

    state_t          r_state, w_next;
    logic            r_op;
    logic [CW-1:0]   r_wcnt;
    logic [TW-1:0]   r_tcnt;
    logic [1:0]      r_status;
    logic [3*BW-1:0] r_opd;
    logic [2*BW-1:0] r_res;
    logic [BW-1:0]   r_k, r_px, r_py;
    logic [BW-1:0]   w_k;
    logic            w_load_end, w_out_end, w_to;

    assign w_k        = r_op ? r_opd[3*BW-1 -: BW] : r_opd[BW-1:0];
    assign w_load_end = r_wcnt == (r_op ? CW'(3 * W - 1) : CW'(W - 1));
    assign w_out_end  = r_wcnt == (r_op ? CW'(W - 1) : CW'(2 * W - 1));
    assign w_to       = r_tcnt == TW'(TIMEOUT - 2);
    assign status     = r_status;
    assign mul_k      = r_k;
    assign mul_Px     = r_px;
    assign mul_Py     = r_py;
    assign out_data   = r_res[2*BW-1 -: IO_W];

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        mul_start = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                w_next    = cmd_valid ? LOAD : IDLE;
            end
            LOAD: begin
                in_ready = 1'b1;
                w_next   = (in_valid && w_load_end) ? CHECK : LOAD;
            end
            CHECK: w_next = (w_k == '0) ? FIN : START;
            START: begin
                mul_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: w_next = mul_valid ? OUT : (w_to ? FIN : WAIT);
            OUT: begin
                out_valid = 1'b1;
                out_last  = w_out_end;
                w_next    = (out_ready && w_out_end) ? FIN : OUT;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= 1'b0;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_status <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op     <= cmd_op;
                    r_status <= 2'd0;
                    r_wcnt   <= '0;
                end
                LOAD: if (in_valid) r_wcnt <= r_wcnt + 1'b1;
                CHECK: if (w_k == '0) r_status <= 2'd1;
                START: r_tcnt <= '0;
                WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (mul_valid) r_wcnt <= '0;
                    else if (w_to) r_status <= 2'd2;
                end
                OUT: if (out_ready) r_wcnt <= r_wcnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD && in_valid) r_opd <= {r_opd[3*BW-IO_W-1:0], in_data};
        if (r_state == CHECK) begin
            r_k  <= w_k;
            r_px <= r_op ? r_opd[2*BW-1 -: BW] : GEN_X;
            r_py <= r_op ? r_opd[BW-1:0] : GEN_Y;
        end
        if (rst_n && r_state == WAIT && mul_valid) r_res <= {mul_Qx, mul_Qy};
        else if (r_state == OUT && out_ready) r_res <= {r_res[2*BW-IO_W-1:0], {IO_W{1'b0}}};
    end
endmodule

// File: tb/tb_ecdh_seq.sv
// tb_ecdh_seq: directed bench for ecdh_seq with a latency-programmable engine model
module tb_ecdh_seq;
    localparam int BW = 192;
    localparam logic [BW-1:0] GX = 192'h188DA80EB03090F67CBF20EB43A18800F4FF0AFD82FF1012;
    localparam logic [BW-1:0] GY = 192'h07192B95FFC8DA78631011ED6B24CDD573F977A11E794811;
    localparam logic [BW-1:0] RX = 192'hDAFEBF5828783F2AD35534631588A3F629A70FB16982A888;
    localparam logic [BW-1:0] RY = 192'hDD6BDA0D993DA0FA46B27BBC141B868F59331AFA5C7E93AB;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready;
    logic          in_valid = 1'b0, in_ready;
    logic [31:0]   in_data = '0, out_data;
    logic          out_valid, out_last, out_ready = 1'b1, done, mul_start, mul_valid = 1'b0;
    logic [1:0]    status;
    logic [BW-1:0] mul_k, mul_Px, mul_Py, mul_Qx = '0, mul_Qy = '0;

    int            n_chk = 0, n_fail = 0, cyc = 0;
    int            n_in, n_start, n_ov, n_done, n_bad, cd = -1, lat = 40;
    int            in_cyc, start_cyc, v_cyc, ov_cyc, done_cyc;
    bit            clr = 1'b0, eng_on = 1'b1, hold, busy;
    logic [1:0]    done_st;
    logic [31:0]   held;
    logic [BW-1:0] k_s, px_s, py_s;
    logic [31:0]   oq[$];
    bit            lq[$];
    logic [31:0]   ld[18];

    ecdh_seq #(.TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .done(done), .status(status), .mul_start(mul_start), .mul_k(mul_k), .mul_Px(mul_Px),
        .mul_Py(mul_Py), .mul_Qx(mul_Qx), .mul_Qy(mul_Qy), .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            n_in = 0; n_start = 0; n_ov = 0; n_done = 0; n_bad = 0;
            hold = 0; busy = 0; cd = -1; mul_valid = 0; ov_cyc = -1; v_cyc = -1;
            oq.delete(); lq.delete();
        end else begin
            mul_valid = 0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    mul_valid = eng_on;
                    if (eng_on) v_cyc = cyc;
                    cd = -1;
                end
            end
            if (!rst_n) busy = 0;
            if (mul_start) begin
                n_start++; start_cyc = cyc; cd = lat; busy = 1;
                k_s = mul_k; px_s = mul_Px; py_s = mul_Py;
            end else if (busy) begin
                if (mul_k !== k_s || mul_Px !== px_s || mul_Py !== py_s) n_bad++;
                if (mul_valid) busy = 0;
            end
            if (out_valid) begin
                if (ov_cyc < 0) ov_cyc = cyc;
                n_ov++;
                if (hold && out_data !== held) n_bad++;
                if (out_ready) begin
                    oq.push_back(out_data); lq.push_back(out_last); hold = 0;
                end else begin
                    hold = 1; held = out_data;
                end
            end else hold = 0;
            if (in_valid && in_ready) begin n_in++; in_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; done_st = status; end
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic set_words(input logic [BW-1:0] k, input logic [BW-1:0] px, input logic [BW-1:0] py);
        for (int i = 0; i < 6; i++) begin
            ld[i]      = k[191-32*i -: 32];
            ld[6 + i]  = px[191-32*i -: 32];
            ld[12 + i] = py[191-32*i -: 32];
        end
    endtask

    task automatic issue(input bit op, input int nw, input bit stall, input bit keep_cmd);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op;
        @(posedge clk); #1;
        cmd_valid = keep_cmd; cmd_op = 1'b0;
        for (int i = 0; i < nw; i++) begin
            for (int s = 0; s < 3 && stall && $urandom_range(0, 2) == 0; s++) begin
                in_valid = 1'b0; @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = ld[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit bp, input int max);
        int k = 0;
        while (n_done == 0 && k < max) begin
            out_ready = bp ? (k % 3 == 0) : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        n_chk++;
        if (n_done != 1) begin n_fail++; $display("FAIL done_pulse: got %0d pulses, want 1", n_done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_chk++;
        if ({cmd_ready, in_ready, out_valid, out_last, mul_start, done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 100000", {cmd_ready, in_ready, out_valid, out_last, mul_start, done});
        end
        n_chk++;
        if (status !== 2'd0) begin n_fail++; $display("FAIL reset_status: got %0d want 0", status); end
        rst_n = 1'b1;
    endtask

    task automatic test_keygen();
        logic [383:0] e = {GX, GY};
        clear_mon(); eng_on = 1; lat = 40; mul_Qx = GX; mul_Qy = GY;
        set_words(192'd1, '0, '0);
        issue(1'b0, 6, 1'b0, 1'b0);
        wait_done(1'b0, 300);
        n_chk++; if (n_start != 1) begin n_fail++; $display("FAIL kg_starts: got %0d want 1", n_start); end
        n_chk++; if (k_s !== 192'd1) begin n_fail++; $display("FAIL kg_k: got %h want 1", k_s); end
        n_chk++; if (px_s !== GX || py_s !== GY) begin n_fail++; $display("FAIL kg_point: got %h %h want G", px_s, py_s); end
        n_chk++; if (start_cyc - in_cyc != 2) begin n_fail++; $display("FAIL kg_start_lat: got %0d want 2", start_cyc - in_cyc); end
        n_chk++; if (ov_cyc - v_cyc != 1) begin n_fail++; $display("FAIL kg_out_lat: got %0d want 1", ov_cyc - v_cyc); end
        n_chk++; if (oq.size() != 12) begin n_fail++; $display("FAIL kg_count: got %0d want 12", oq.size()); end
        for (int i = 0; i < oq.size() && i < 12; i++) begin
            n_chk++;
            if (oq[i] !== e[383-32*i -: 32] || lq[i] !== (i == 11)) begin
                n_fail++;
                $display("FAIL kg_word%0d: got %h last %b want %h last %b", i, oq[i], lq[i], e[383-32*i -: 32], i == 11);
            end
        end
        n_chk++; if (done_st !== 2'd0 || n_bad != 0) begin n_fail++; $display("FAIL kg_status: got %0d bad %0d want 0 0", done_st, n_bad); end
    endtask

    task automatic test_shared();
        clear_mon(); eng_on = 1; lat = 25; mul_Qx = RX; mul_Qy = RY;
        set_words(192'd2, GX, GY);
        issue(1'b1, 18, 1'b0, 1'b1);
        wait_done(1'b0, 300);
        n_chk++; if (n_in != 18) begin n_fail++; $display("FAIL ss_loaded: got %0d want 18", n_in); end
        n_chk++; if (k_s !== 192'd2 || px_s !== GX || py_s !== GY) begin n_fail++; $display("FAIL ss_operands: got %h %h %h", k_s, px_s, py_s); end
        n_chk++; if (oq.size() != 6) begin n_fail++; $display("FAIL ss_count: got %0d want 6", oq.size()); end
        for (int i = 0; i < oq.size() && i < 6; i++) begin
            n_chk++;
            if (oq[i] !== RX[191-32*i -: 32] || lq[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL ss_word%0d: got %h last %b want %h last %b", i, oq[i], lq[i], RX[191-32*i -: 32], i == 5);
            end
        end
        n_chk++; if (done_st !== 2'd0) begin n_fail++; $display("FAIL ss_status: got %0d want 0", done_st); end
    endtask

    task automatic test_k_zero();
        clear_mon(); eng_on = 1; lat = 10;
        set_words('0, GX, GY);
        issue(1'b0, 6, 1'b0, 1'b0);
        wait_done(1'b0, 50);
        n_chk++; if (n_start != 0) begin n_fail++; $display("FAIL k0_starts: got %0d want 0", n_start); end
        n_chk++; if (done_cyc - in_cyc != 2) begin n_fail++; $display("FAIL k0_done_lat: got %0d want 2", done_cyc - in_cyc); end
        n_chk++; if (done_st !== 2'd1) begin n_fail++; $display("FAIL k0_status: got %0d want 1", done_st); end
        n_chk++; if (n_ov != 0) begin n_fail++; $display("FAIL k0_out: got %0d valid cycles want 0", n_ov); end
    endtask

    task automatic test_timeout();
        clear_mon(); eng_on = 0;
        set_words(192'd1, '0, '0);
        issue(1'b0, 6, 1'b0, 1'b0);
        wait_done(1'b0, 200);
        n_chk++; if (cmd_ready !== 1'b1 || status !== 2'd2) begin n_fail++; $display("FAIL to_idle: got ready %b status %0d want 1 2", cmd_ready, status); end
        n_chk++; if (done_st !== 2'd2) begin n_fail++; $display("FAIL to_status: got %0d want 2", done_st); end
        n_chk++; if (done_cyc - start_cyc != 64) begin n_fail++; $display("FAIL to_cycles: got %0d want 64", done_cyc - start_cyc); end
        n_chk++; if (n_ov != 0) begin n_fail++; $display("FAIL to_out: got %0d want 0", n_ov); end
    endtask

    task automatic test_timeout_edge();
        clear_mon(); eng_on = 1; lat = 63; mul_Qx = GX; mul_Qy = GY;
        set_words(192'd7, '0, '0);
        issue(1'b0, 6, 1'b0, 1'b0);
        wait_done(1'b0, 300);
        n_chk++; if (done_st !== 2'd0 || oq.size() != 12) begin n_fail++; $display("FAIL edge63: got status %0d words %0d want 0 12", done_st, oq.size()); end
        clear_mon(); eng_on = 1; lat = 64;
        issue(1'b0, 6, 1'b0, 1'b0);
        wait_done(1'b0, 300);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (done_st !== 2'd2 || n_ov != 0) begin n_fail++; $display("FAIL edge64: got status %0d valid %0d want 2 0", done_st, n_ov); end
    endtask

    task automatic test_back_to_back();
        logic [383:0] e = {RX, RY};
        clear_mon(); eng_on = 1; lat = 20; mul_Qx = RX; mul_Qy = RY;
        set_words(192'd3, '0, '0);
        issue(1'b0, 6, 1'b1, 1'b0);
        wait_done(1'b1, 400);
        n_chk++; if (oq.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", oq.size()); end
        for (int i = 0; i < oq.size() && i < 12; i++) begin
            n_chk++;
            if (oq[i] !== e[383-32*i -: 32] || lq[i] !== (i == 11)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h last %b want %h last %b", i, oq[i], lq[i], e[383-32*i -: 32], i == 11);
            end
        end
        n_chk++; if (n_bad != 0 || done_st !== 2'd0) begin n_fail++; $display("FAIL bp_stable: got unstable %0d status %0d want 0 0", n_bad, done_st); end
        clear_mon();
        set_words(192'd9, RY, RX);
        issue(1'b1, 18, 1'b1, 1'b0);
        wait_done(1'b1, 400);
        n_chk++; if (px_s !== RY || py_s !== RX || k_s !== 192'd9) begin n_fail++; $display("FAIL b2b_operands: got %h %h %h", k_s, px_s, py_s); end
        n_chk++; if (oq.size() != 6 || n_bad != 0) begin n_fail++; $display("FAIL b2b_count: got %0d unstable %0d want 6 0", oq.size(), n_bad); end
        for (int i = 0; i < oq.size() && i < 6; i++) begin
            n_chk++;
            if (oq[i] !== RX[191-32*i -: 32]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, oq[i], RX[191-32*i -: 32]); end
        end
    endtask

    task automatic test_reset_wait();
        clear_mon(); eng_on = 1; lat = 30; mul_Qx = GX; mul_Qy = GY;
        set_words(192'd5, '0, '0);
        issue(1'b0, 6, 1'b0, 1'b0);
        repeat (10) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++; if (cmd_ready !== 1'b1 || status !== 2'd0) begin n_fail++; $display("FAIL rw_idle: got ready %b status %0d want 1 0", cmd_ready, status); end
        repeat (40) @(posedge clk); #1;
        n_chk++; if (n_start != 1) begin n_fail++; $display("FAIL rw_starts: got %0d want 1", n_start); end
        n_chk++; if (n_ov != 0 || n_done != 0) begin n_fail++; $display("FAIL rw_out: got valid %0d done %0d want 0 0", n_ov, n_done); end
        n_chk++; if (cmd_ready !== 1'b1 || status !== 2'd0) begin n_fail++; $display("FAIL rw_final: got ready %b status %0d want 1 0", cmd_ready, status); end
    endtask

    initial begin
        test_reset();
        test_keygen();
        test_shared();
        test_k_zero();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
